// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: three-phase vehicle signal with pedestrian walk, night flashing-yellow mode
// and a two-digit BCD countdown of seconds remaining in the current phase.
//
// Ports:
//   clk      - system clock, all logic on posedge
//   rst_n    - asynchronous active-low reset
//   btn      - pedestrian button, active-low, asynchronous to clk
//   night    - night-mode request, active-high, asynchronous to clk
//   light_g  - vehicle green
//   light_y  - vehicle yellow (blinks in night mode)
//   light_r  - vehicle red
//   ped_walk - pedestrian walk, high only while vehicles see red
//   ped_req  - pedestrian request latched and pending
//   bcd0     - units digit of seconds remaining
//   bcd1     - tens digit of seconds remaining
module semaforo_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned T_VERDE     = 10,
    parameter int unsigned T_AMARELO   = 3,
    parameter int unsigned T_VERMELHO  = 8,
    parameter int unsigned T_MIN_VERDE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       night,
    output logic       light_g,
    output logic       light_y,
    output logic       light_r,
    output logic       ped_walk,
    output logic       ped_req,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1
);

    localparam logic [1:0] S_VERDE    = 2'd0;
    localparam logic [1:0] S_AMARELO  = 2'd1;
    localparam logic [1:0] S_VERMELHO = 2'd2;
    localparam logic [1:0] S_PISCA    = 2'd3;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [6:0] D_VERDE    = 7'(T_VERDE);
    localparam logic [6:0] D_AMARELO  = 7'(T_AMARELO);
    localparam logic [6:0] D_VERMELHO = 7'(T_VERMELHO);
    // Elapsed green ticks (T_VERDE - remaining + 1) >= T_MIN_VERDE, rearranged onto remaining.
    localparam logic [6:0] CUT_REM    = 7'(T_VERDE + 1 - T_MIN_VERDE);

    logic [1:0]    r_state;
    logic [1:0]    w_state_d;
    logic [6:0]    r_rem;
    logic [6:0]    w_dur;
    logic [PW-1:0] r_presc;
    logic          r_blink;
    logic          r_ped_req;
    logic          r_btn_s1, r_btn_s2, r_btn_prev;
    logic          r_night_s1, r_night_s2;

    logic          w_tick;
    logic          w_last;
    logic          w_min_ok;
    logic          w_press;
    logic          w_chg;
    logic [6:0]    w_tens;
    logic [6:0]    w_units;

    assign w_tick   = (r_presc == PRESC_MAX);
    assign w_last   = (r_rem == 7'd1);
    assign w_min_ok = (r_rem <= CUT_REM);
    // Falling edge of the synchronised button; holding it low yields a single press.
    assign w_press  = r_btn_prev & ~r_btn_s2;
    assign w_chg    = (w_state_d != r_state);

    // Two-flop synchronisers plus the edge-detect history flop for the button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1   <= 1'b1;
            r_btn_s2   <= 1'b1;
            r_btn_prev <= 1'b1;
            r_night_s1 <= 1'b0;
            r_night_s2 <= 1'b0;
        end else begin
            r_btn_s1   <= btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            r_night_s1 <= night;
            r_night_s2 <= r_night_s1;
        end
    end

    // Phase transitions only ever happen on a one-second tick.
    always_comb begin
        w_state_d = r_state;
        if (w_tick) begin
            case (r_state)
                S_VERDE: begin
                    if (w_last || (r_ped_req && w_min_ok) || r_night_s2) w_state_d = S_AMARELO;
                end
                S_AMARELO: begin
                    if (w_last) w_state_d = r_night_s2 ? S_PISCA : S_VERMELHO;
                end
                S_VERMELHO: begin
                    if (w_last) w_state_d = r_night_s2 ? S_PISCA : S_VERDE;
                end
                default: begin
                    if (!r_night_s2) w_state_d = S_VERMELHO;
                end
            endcase
        end
    end

    always_comb begin
        w_dur = 7'd0;
        case (w_state_d)
            S_VERDE:    w_dur = D_VERDE;
            S_AMARELO:  w_dur = D_AMARELO;
            S_VERMELHO: w_dur = D_VERMELHO;
            default:    w_dur = 7'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_VERMELHO;
            r_rem   <= D_VERMELHO;
            r_presc <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_chg) begin
                // Each phase starts on a full second with its own duration loaded.
                r_presc <= '0;
                r_rem   <= w_dur;
                r_blink <= (w_state_d == S_PISCA);
            end else begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    if (r_state == S_PISCA) r_blink <= ~r_blink;
                    else if (r_rem != 7'd0) r_rem <= r_rem - 7'd1;
                end
            end
        end
    end

    // Entering red clears the request even if a press lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_req <= 1'b0;
        end else if (w_chg && (w_state_d == S_VERMELHO)) begin
            r_ped_req <= 1'b0;
        end else if (w_press && ((r_state == S_VERDE) || (r_state == S_AMARELO))) begin
            r_ped_req <= 1'b1;
        end
    end

    assign light_g  = (r_state == S_VERDE);
    assign light_y  = (r_state == S_AMARELO) || ((r_state == S_PISCA) && r_blink);
    assign light_r  = (r_state == S_VERMELHO);
    assign ped_walk = (r_state == S_VERMELHO);
    assign ped_req  = r_ped_req;

    assign w_tens  = r_rem / 7'd10;
    assign w_units = r_rem % 7'd10;
    assign bcd1    = w_tens[3:0];
    assign bcd0    = w_units[3:0];

endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb_semaforo_ctrl: directed bench for semaforo_ctrl with TICK_DIV=4 and default durations.
// Edge numbers below count posedges since the latest reset release; samples are taken
// 1 time unit after each posedge.
module tb_semaforo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       night;
    logic       light_g, light_y, light_r, ped_walk, ped_req;
    logic [3:0] bcd0, bcd1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // {g, y, r, walk, req}
    localparam logic [4:0] L_VERM   = 5'b00110;
    localparam logic [4:0] L_VERD   = 5'b10000;
    localparam logic [4:0] L_VERD_Q = 5'b10001;
    localparam logic [4:0] L_AMAR   = 5'b01000;
    localparam logic [4:0] L_AMAR_Q = 5'b01001;
    localparam logic [4:0] L_OFF    = 5'b00000;

    semaforo_ctrl #(
        .TICK_DIV   (4),
        .T_VERDE    (10),
        .T_AMARELO  (3),
        .T_VERMELHO (8),
        .T_MIN_VERDE(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .night   (night),
        .light_g (light_g),
        .light_y (light_y),
        .light_r (light_r),
        .ped_walk(ped_walk),
        .ped_req (ped_req),
        .bcd0    (bcd0),
        .bcd1    (bcd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] lights, input logic [7:0] bcd);
        chk({tag, "_lights"}, {11'd0, light_g, light_y, light_r, ped_walk, ped_req},
            {11'd0, lights});
        chk({tag, "_bcd"}, {8'd0, bcd1, bcd0}, {8'd0, bcd});
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        btn   = 1'b1;
        night = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_st("reset", L_VERM, 8'h08);
        repeat (2) @(posedge clk);
        release_reset();

        // 1: plain cycle red 32, green 40, yellow 12, red again
        run_to(3);   chk_st("s1_red_start", L_VERM, 8'h08);
        run_to(4);   chk_st("s1_red_7", L_VERM, 8'h07);
        run_to(31);  chk_st("s1_red_last", L_VERM, 8'h01);
        run_to(32);  chk_st("s1_green_in", L_VERD, 8'h10);
        run_to(71);  chk_st("s1_green_last", L_VERD, 8'h01);
        run_to(72);  chk_st("s1_yel_in", L_AMAR, 8'h03);
        run_to(83);  chk_st("s1_yel_last", L_AMAR, 8'h01);
        run_to(84);  chk_st("s1_red2_in", L_VERM, 8'h08);

        // 2: early press, cut waits for minimum green (tick 4, edge 132)
        run_to(118); btn = 1'b0;
        run_to(120); btn = 1'b1;
        chk_st("s2_no_req_yet", L_VERD, 8'h09);
        run_to(121); chk_st("s2_req_set", L_VERD_Q, 8'h09);
        run_to(131); chk_st("s2_green_hold", L_VERD_Q, 8'h07);
        run_to(132); chk_st("s2_cut", L_AMAR_Q, 8'h03);
        run_to(144); chk_st("s2_red_clear", L_VERM, 8'h08);

        // 3: late press at green tick 7 cuts at the next tick
        run_to(204); btn = 1'b0;
        run_to(206); btn = 1'b1;
        run_to(207); chk_st("s3_req", L_VERD_Q, 8'h03);
        run_to(208); chk_st("s3_cut", L_AMAR_Q, 8'h03);
        run_to(220); chk_st("s3_red", L_VERM, 8'h08);

        // 4: button held low through red is ignored; next green is full length
        btn = 1'b0;
        run_to(251); chk_st("s4_red_end", L_VERM, 8'h01);
        run_to(252); chk_st("s4_green_in", L_VERD, 8'h10);
        btn = 1'b1;
        run_to(291); chk_st("s4_green_full", L_VERD, 8'h01);
        run_to(292); chk_st("s4_yel", L_AMAR, 8'h03);

        // 5: night mode mid-green, then flashing yellow, then back to red
        run_to(341); night = 1'b1;
        run_to(343); chk_st("s5_green_hold", L_VERD, 8'h09);
        run_to(344); chk_st("s5_yel", L_AMAR, 8'h03);
        run_to(356); chk_st("s5_pisca_on", L_AMAR, 8'h00);
        run_to(359); chk_st("s5_pisca_on2", L_AMAR, 8'h00);
        run_to(360); chk_st("s5_pisca_off", L_OFF, 8'h00);
        run_to(364); chk_st("s5_pisca_on3", L_AMAR, 8'h00);
        run_to(365); night = 1'b0;
        run_to(367); chk_st("s5_pisca_hold", L_AMAR, 8'h00);
        run_to(368); chk_st("s5_red", L_VERM, 8'h08);

        // 6: asynchronous reset mid-yellow, then the sequence restarts
        run_to(440); chk_st("s6_yel", L_AMAR, 8'h03);
        run_to(445);
        #3 rst_n = 1'b0;
        #1 chk_st("s6_async_rst", L_VERM, 8'h08);
        release_reset();
        run_to(3);   chk_st("s6_red_start", L_VERM, 8'h08);
        run_to(32);  chk_st("s6_green_in", L_VERD, 8'h10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
